// File: rtl/mem_access_unit_pkg.sv
// Shared types and widths for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Both MemRead and MemWrite set is treated as a store.
  function automatic logic is_access(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
// Handshake: mem_req_o rises with we/addr/wdata valid and holds them stable until the
// cycle mem_ack_i is high (transfer done, rdata valid for reads) or the unit aborts.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_access_unit_wait_timer.sv
// Counts BUSY cycles without an acknowledge; flags the cycle on which the access must abort.
module mem_wait_timer #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_q;

  assign expired_o = (count_q == CW'(MAX_WAIT - 1));

  // Holding at the terminal value keeps the count from ever wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores from EX/MEM on the memory port, stalls while an access
// is outstanding, and registers the WB-side outputs (ALU result or load data).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [XLEN-1:0]       ALUout_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  mem_access_unit_if.master     mem,
  output logic                  stall_o,
  output logic                  RegWrite_o,
  output logic                  MemtoReg_o,
  output logic [XLEN-1:0]       ALUout_o,
  output logic [XLEN-1:0]       mem_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  err_o,
  output state_e                dbg_state_o
);

  state_e                state_q;
  logic                  req_q;
  logic                  we_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  reg_write_q;
  logic                  mem_to_reg_q;
  logic [XLEN-1:0]       alu_out_q;
  logic [XLEN-1:0]       mem_data_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic                  err_q;

  logic access;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign access      = is_access(MemRead_i, MemWrite_i);
  assign timer_clear = (state_q == ST_IDLE);
  assign timer_en    = (state_q == ST_BUSY) && !mem.mem_ack_i;

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: stall_o = access;
      ST_BUSY: stall_o = !mem.mem_ack_i;
      default: stall_o = 1'b0;
    endcase
  end

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  // While an access is in flight, WB sees a bubble; ALUout/rd/mem_data simply hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_out_q    <= '0;
      mem_data_q   <= '0;
      rd_addr_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            state_q      <= ST_BUSY;
            req_q        <= 1'b1;
            we_q         <= MemWrite_i;
            addr_q       <= ALUout_i;
            wdata_q      <= rs2_data_i;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
          end else begin
            reg_write_q  <= RegWrite_i;
            mem_to_reg_q <= MemtoReg_i;
            alu_out_q    <= ALUout_i;
            rd_addr_q    <= rd_addr_i;
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack_i) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            reg_write_q  <= RegWrite_i;
            mem_to_reg_q <= MemtoReg_i;
            alu_out_q    <= ALUout_i;
            rd_addr_q    <= rd_addr_i;
            if (!we_q) begin
              mem_data_q <= mem.mem_rdata_i;
            end
          end else if (timer_expired) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            err_q        <= 1'b1;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
          end else begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

  assign RegWrite_o  = reg_write_q;
  assign MemtoReg_o  = mem_to_reg_q;
  assign ALUout_o    = alu_out_q;
  assign mem_data_o  = mem_data_q;
  assign rd_addr_o   = rd_addr_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
